// File: rtl/coin_pkg.sv
// Shared coin types and cent values for the coin qualifier.
// Optional running total is built when COIN_TOTAL_EN is defined.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_NICKEL,
    COIN_DIME,
    COIN_QUARTER
  } coin_t;

  localparam logic [4:0] CENTS_NICKEL  = 5'd5;
  localparam logic [4:0] CENTS_DIME    = 5'd10;
  localparam logic [4:0] CENTS_QUARTER = 5'd25;

  function automatic logic [4:0] coin_cents(input coin_t c);
    logic [4:0] v;
    unique case (c)
      COIN_NICKEL:  v = CENTS_NICKEL;
      COIN_DIME:    v = CENTS_DIME;
      COIN_QUARTER: v = CENTS_QUARTER;
      default:      v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// Synchroniser, debouncer and rising-event detect for one coin line.
// Stable level resets high so a line stuck high at reset is ignored.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   r_stable_d;
  logic                   w_synced;
  logic                   w_diff;
  logic                   w_done;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_diff   = w_synced != r_stable;
  assign w_done   = r_cnt == CW'(DEBOUNCE_CYCLES - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync     <= '0;
      r_cnt      <= '0;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_stable_d <= r_stable;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt    <= '0;
        r_stable <= w_synced;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise = r_stable & ~r_stable_d;

endmodule

// File: rtl/coin_sense.sv
// Coin qualifier: debounce three lines, arbitrate into one-hot pulses.
// Define COIN_TOTAL_EN to add the saturating total_cents output.
module coin_sense
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coin_n_raw,
  input  logic        coin_d_raw,
  input  logic        coin_q_raw,
  input  logic        hold,
  output logic        N,
  output logic        D,
  output logic        Q,
  output logic        coin_reject
`ifdef COIN_TOTAL_EN
  ,
  output logic [15:0] total_cents
`endif
);

  logic  w_ev_n;
  logic  w_ev_d;
  logic  w_ev_q;
  logic  w_multi;
  logic  w_ok;
  logic  w_rej;
  coin_t w_evt;
  coin_t w_emit;
  coin_t w_slot_nx;
  coin_t r_slot;
  logic  r_gap;
  logic  r_n;
  logic  r_d;
  logic  r_q;
  logic  r_rej;

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_db_n (
    .clk   (clk),
    .rst   (rst),
    .i_raw (coin_n_raw),
    .o_rise(w_ev_n)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_db_d (
    .clk   (clk),
    .rst   (rst),
    .i_raw (coin_d_raw),
    .o_rise(w_ev_d)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_db_q (
    .clk   (clk),
    .rst   (rst),
    .i_raw (coin_q_raw),
    .o_rise(w_ev_q)
  );

  assign w_multi = (w_ev_n & w_ev_d) |
                   (w_ev_n & w_ev_q) |
                   (w_ev_d & w_ev_q);
  assign w_ok    = !hold && !r_gap;

  always_comb begin
    w_evt = COIN_NONE;
    if (!w_multi) begin
      unique case (1'b1)
        w_ev_n:  w_evt = COIN_NICKEL;
        w_ev_d:  w_evt = COIN_DIME;
        w_ev_q:  w_evt = COIN_QUARTER;
        default: w_evt = COIN_NONE;
      endcase
    end
  end

  // Simultaneous events freeze the slot and suppress any emission.
  always_comb begin
    w_emit    = COIN_NONE;
    w_slot_nx = r_slot;
    w_rej     = 1'b0;
    if (w_multi) begin
      w_rej = 1'b1;
    end else if (r_slot != COIN_NONE && w_ok) begin
      w_emit    = r_slot;
      w_slot_nx = w_evt;
    end else if (w_evt != COIN_NONE) begin
      if (r_slot != COIN_NONE) begin
        w_rej = 1'b1;
      end else if (w_ok) begin
        w_emit = w_evt;
      end else begin
        w_slot_nx = w_evt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot <= COIN_NONE;
      r_gap  <= 1'b0;
      r_n    <= 1'b0;
      r_d    <= 1'b0;
      r_q    <= 1'b0;
      r_rej  <= 1'b0;
    end else begin
      r_slot <= w_slot_nx;
      r_gap  <= w_emit != COIN_NONE;
      r_n    <= w_emit == COIN_NICKEL;
      r_d    <= w_emit == COIN_DIME;
      r_q    <= w_emit == COIN_QUARTER;
      r_rej  <= w_rej;
    end
  end

  assign N           = r_n;
  assign D           = r_d;
  assign Q           = r_q;
  assign coin_reject = r_rej;

`ifdef COIN_TOTAL_EN
  logic [15:0] r_total;
  logic [16:0] w_sum;

  assign w_sum = {1'b0, r_total} + 17'(coin_cents(w_emit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_total <= '0;
    end else begin
      r_total <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  assign total_cents = r_total;
`endif

endmodule

// File: tb/tb_coin_sense.sv
// Self-checking bench for coin_sense with a cycle-level reference model.
// Build with COIN_TOTAL_EN defined to also check total_cents.
module tb_coin_sense;

  localparam int DEB = 16;
  localparam int SYN = 2;
  localparam int LAT = SYN + DEB + 1;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic n_raw = 1'b0;
  logic d_raw = 1'b0;
  logic q_raw = 1'b0;
  logic hold  = 1'b0;
  logic N;
  logic D;
  logic Q;
  logic rej;
`ifdef COIN_TOTAL_EN
  logic [15:0] total;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coin_sense #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_n_raw (n_raw),
    .coin_d_raw (d_raw),
    .coin_q_raw (q_raw),
    .hold       (hold),
    .N          (N),
    .D          (D),
    .Q          (Q),
    .coin_reject(rej)
`ifdef COIN_TOTAL_EN
    ,
    .total_cents(total)
`endif
  );

  // Pulse counters and rule-violation counter
  int   cnt_n = 0;
  int   cnt_d = 0;
  int   cnt_q = 0;
  int   cnt_r = 0;
  int   viol  = 0;
  logic last_any = 1'b0;

  task automatic monitor_tick();
    if (N) cnt_n++;
    if (D) cnt_d++;
    if (Q) cnt_q++;
    if (rej) cnt_r++;
    if ((int'(N) + int'(D) + int'(Q)) > 1) viol++;
    if ((N | D | Q) && last_any) viol++;
    last_any = N | D | Q;
  endtask

  always @(negedge clk) monitor_tick();

  // Reference model: coin index 0 none, 1 nickel, 2 dime, 3 quarter
  logic [2:0] m_hist[$];
  logic [2:0] m_lvl  = 3'b111;
  logic [2:0] m_pend = 3'b000;
  int         m_run[3];
  int         m_slot = 0;
  bit         m_gap  = 1'b0;
  logic       e_n = 1'b0;
  logic       e_d = 1'b0;
  logic       e_q = 1'b0;
  logic       e_r = 1'b0;
`ifdef COIN_TOTAL_EN
  int         m_total = 0;
  int         cents[4] = '{0, 5, 10, 25};
`endif

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i < SYN; i++) m_hist.push_back(3'b000);
    m_lvl  = 3'b111;
    m_pend = 3'b000;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_slot = 0;
    m_gap  = 1'b0;
    e_n = 1'b0;
    e_d = 1'b0;
    e_q = 1'b0;
    e_r = 1'b0;
`ifdef COIN_TOTAL_EN
    m_total = 0;
`endif
  endtask

  task automatic model_tick();
    int ne;
    int ev;
    int emit;
    bit ok;
    bit rj;
    logic [2:0] s;
    ok   = !hold && !m_gap;
    ne   = $countones(m_pend);
    ev   = m_pend[0] ? 1 : m_pend[1] ? 2 : m_pend[2] ? 3 : 0;
    emit = 0;
    rj   = 1'b0;
    if (ne > 1) begin
      rj = 1'b1;
    end else if (m_slot != 0 && ok) begin
      emit   = m_slot;
      m_slot = ev;
    end else if (ev != 0) begin
      if (m_slot != 0) rj = 1'b1;
      else if (ok) emit = ev;
      else m_slot = ev;
    end
    m_gap = emit != 0;
    e_n = emit == 1;
    e_d = emit == 2;
    e_q = emit == 3;
    e_r = rj;
`ifdef COIN_TOTAL_EN
    m_total = m_total + cents[emit];
    if (m_total > 65535) m_total = 65535;
`endif
    s = m_hist.pop_front();
    m_hist.push_back({q_raw, d_raw, n_raw});
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 1'b0;
      if (s[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i]  = s[i];
          m_run[i]  = 0;
          m_pend[i] = s[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_tick();
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    step(2);
    #1;
    checks++;
    if ({N, D, Q, rej} !== 4'b0000)
      $display("FAIL reset_outs got %b want 0000", {N, D, Q, rej});
    if ({N, D, Q, rej} !== 4'b0000) errors++;
`ifdef COIN_TOTAL_EN
    checks++;
    if (total !== 16'd0) begin
      $display("FAIL reset_total got %0d want 0", total);
      errors++;
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    step(40);
  endtask

  task automatic test_nickel();
    int bn, bd, bq, br, first;
    bn = cnt_n; bd = cnt_d; bq = cnt_q; br = cnt_r;
    first = -1;
    n_raw = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (N && first < 0) first = i;
    end
    n_raw = 1'b0;
    step(40);
    #1;
    checks++;
    if (first != LAT) begin
      $display("FAIL nickel_latency got %0d want %0d", first, LAT);
      errors++;
    end
    checks++;
    if (cnt_n - bn != 1) begin
      $display("FAIL nickel_count got %0d want 1", cnt_n - bn);
      errors++;
    end
    checks++;
    if ((cnt_d - bd) + (cnt_q - bq) + (cnt_r - br) != 0) begin
      $display("FAIL nickel_others got %0d want 0",
               (cnt_d - bd) + (cnt_q - bq) + (cnt_r - br));
      errors++;
    end
  endtask

  task automatic test_bounce();
    int bd, br;
    bd = cnt_d; br = cnt_r;
    for (int k = 0; k < 10; k++) begin
      d_raw = ~d_raw;
      step(3);
    end
    d_raw = 1'b1;
    step(40);
    d_raw = 1'b0;
    step(40);
    #1;
    checks++;
    if (cnt_d - bd != 1) begin
      $display("FAIL bounce_dcount got %0d want 1", cnt_d - bd);
      errors++;
    end
    checks++;
    if (cnt_r - br != 0) begin
      $display("FAIL bounce_reject got %0d want 0", cnt_r - br);
      errors++;
    end
  endtask

  task automatic test_simul();
    int bn, bq, br;
    bn = cnt_n; bq = cnt_q; br = cnt_r;
    n_raw = 1'b1;
    q_raw = 1'b1;
    step(40);
    n_raw = 1'b0;
    q_raw = 1'b0;
    step(40);
    #1;
    checks++;
    if (cnt_r - br != 1) begin
      $display("FAIL simul_reject got %0d want 1", cnt_r - br);
      errors++;
    end
    checks++;
    if ((cnt_n - bn) + (cnt_q - bq) != 0) begin
      $display("FAIL simul_coins got %0d want 0",
               (cnt_n - bn) + (cnt_q - bq));
      errors++;
    end
  endtask

  task automatic test_hold();
    int bd, bq, br;
    bd = cnt_d; bq = cnt_q; br = cnt_r;
    hold  = 1'b1;
    d_raw = 1'b1;
    step(25);
    d_raw = 1'b0;
    q_raw = 1'b1;
    step(25);
    q_raw = 1'b0;
    step(20);
    #1;
    checks++;
    if (cnt_r - br != 1 || cnt_d - bd != 0) begin
      $display("FAIL hold_reject rej %0d d %0d want 1 0",
               cnt_r - br, cnt_d - bd);
      errors++;
    end
    hold = 1'b0;
    @(negedge clk);
    checks++;
    if (D !== 1'b1) begin
      $display("FAIL hold_release got %b want 1", D);
      errors++;
    end
    step(10);
    #1;
    checks++;
    if (cnt_d - bd != 1 || cnt_q - bq != 0) begin
      $display("FAIL hold_counts d %0d q %0d want 1 0",
               cnt_d - bd, cnt_q - bq);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    int d_at, q_at;
    d_at = -1;
    q_at = -1;
    d_raw = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 1) q_raw = 1'b1;
      if (D && d_at < 0) d_at = i;
      if (Q && q_at < 0) q_at = i;
    end
    d_raw = 1'b0;
    q_raw = 1'b0;
    step(40);
    checks++;
    if (d_at != LAT) begin
      $display("FAIL b2b_dime got %0d want %0d", d_at, LAT);
      errors++;
    end
    checks++;
    if (q_at != LAT + 2) begin
      $display("FAIL b2b_quarter got %0d want %0d", q_at, LAT + 2);
      errors++;
    end
  endtask

  task automatic test_stuck();
    int bn, first;
    @(negedge clk);
    rst   = 1'b0;
    n_raw = 1'b1;
    step(3);
    rst = 1'b1;
    bn  = cnt_n;
    step(100);
    #1;
    checks++;
    if (cnt_n - bn != 0) begin
      $display("FAIL stuck_quiet got %0d want 0", cnt_n - bn);
      errors++;
    end
    n_raw = 1'b0;
    step(20);
    first = -1;
    n_raw = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (N && first < 0) first = i;
    end
    n_raw = 1'b0;
    step(40);
    #1;
    checks++;
    if (first != LAT || cnt_n - bn != 1) begin
      $display("FAIL stuck_rise at %0d count %0d want %0d 1",
               first, cnt_n - bn, LAT);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    int bd, br;
    hold  = 1'b1;
    d_raw = 1'b1;
    step(25);
    bd = cnt_d; br = cnt_r;
    rst = 1'b0;
    #1;
    checks++;
    if ({N, D, Q, rej} !== 4'b0000) begin
      $display("FAIL midreset_outs got %b want 0000", {N, D, Q, rej});
      errors++;
    end
    d_raw = 1'b0;
    step(2);
    rst  = 1'b1;
    hold = 1'b0;
    step(40);
    #1;
    checks++;
    if (cnt_d - bd != 0 || cnt_r - br != 0) begin
      $display("FAIL midreset_lost d %0d rej %0d want 0 0",
               cnt_d - bd, cnt_r - br);
      errors++;
    end
  endtask

`ifdef COIN_TOTAL_EN
  task automatic test_total();
    @(negedge clk);
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(30);
    n_raw = 1'b1; step(40); n_raw = 1'b0; step(40);
    d_raw = 1'b1; step(40); d_raw = 1'b0; step(40);
    q_raw = 1'b1; step(40); q_raw = 1'b0; step(40);
    checks++;
    if (total !== 16'd40) begin
      $display("FAIL total_sum got %0d want 40", total);
      errors++;
    end
  endtask
`endif

  task automatic test_random();
    int seg[4];
    for (int i = 0; i < 4; i++) seg[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      checks++;
      if ({N, D, Q, rej} !== {e_n, e_d, e_q, e_r}) begin
        $display("FAIL random_cyc%0d got %b want %b", c,
                 {N, D, Q, rej}, {e_n, e_d, e_q, e_r});
        errors++;
      end
`ifdef COIN_TOTAL_EN
      checks++;
      if (int'(total) != m_total) begin
        $display("FAIL random_total got %0d want %0d", total, m_total);
        errors++;
      end
`endif
      for (int i = 0; i < 4; i++) begin
        if (seg[i] == 0) begin
          seg[i] = $urandom_range(1, 40);
          case (i)
            0: n_raw = $urandom_range(0, 1) == 1;
            1: d_raw = $urandom_range(0, 1) == 1;
            2: q_raw = $urandom_range(0, 1) == 1;
            default: hold = $urandom_range(0, 9) < 3;
          endcase
        end else begin
          seg[i]--;
        end
      end
    end
    n_raw = 1'b0;
    d_raw = 1'b0;
    q_raw = 1'b0;
    hold  = 1'b0;
    step(40);
  endtask

  task automatic test_spacing();
    #1;
    checks++;
    if (viol != 0) begin
      $display("FAIL spacing_violations got %0d want 0", viol);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_nickel();
    test_bounce();
    test_simul();
    test_hold();
    test_back_to_back();
    test_stuck();
    test_reset_mid();
`ifdef COIN_TOTAL_EN
    test_total();
`endif
    test_random();
    test_spacing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
